// File: rtl/apb_initiator.sv
// APB initiator: turns one cmd_valid/cmd_ready request into a single APB
// transfer (SETUP then ACCESS) and reports completion with a one-cycle rsp_valid.
module apb_initiator #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic                  cmd_write,
    input  logic [3:0]            cmd_strb,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [3:0]            pstb,
    input  logic                  pready,
    input  logic                  perr
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             accept;
    logic             timeout_hit;

    assign accept      = cmd_valid && cmd_ready;
    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; pready takes priority over an expiring wait counter
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (pready || timeout_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from the registered state
    always_comb begin
        cmd_ready = 1'b0;
        psel      = 1'b0;
        penable   = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE:    cmd_ready = !reset;
            SETUP:   psel      = 1'b1;
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
            end
            RESP:    rsp_valid = 1'b1;
            default: cmd_ready = 1'b0;
        endcase
    end

    // Request capture, ACCESS wait counter and response capture
    always_ff @(posedge clk) begin
        if (reset) begin
            paddr       <= '0;
            pdata       <= '0;
            pwrite      <= 1'b0;
            pstb        <= '0;
            wait_cnt    <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            if (accept) begin
                paddr  <= cmd_addr;
                pdata  <= cmd_wdata;
                pwrite <= cmd_write;
                pstb   <= cmd_strb;
            end

            if (state != ACCESS) begin
                wait_cnt <= '0;
            end else if (!pready) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end

            if (state == ACCESS) begin
                if (pready) begin
                    rsp_rdata   <= pwrite ? '0 : prdata;
                    rsp_err     <= perr;
                    rsp_timeout <= 1'b0;
                end else if (timeout_hit) begin
                    rsp_rdata   <= '0;
                    rsp_err     <= 1'b1;
                    rsp_timeout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_initiator.sv
// Scoreboard bench for apb_initiator: directed transfers push expected responses,
// a monitor pops and compares on every rsp_valid pulse.
module tb_apb_initiator;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        cmd_write;
    logic [3:0]  cmd_strb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] paddr;
    logic [31:0] pdata;
    logic [31:0] prdata;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [3:0]  pstb;
    logic        pready;
    logic        perr;

    apb_initiator #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT   (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_write  (cmd_write),
        .cmd_strb   (cmd_strb),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .paddr      (paddr),
        .pdata      (pdata),
        .prdata     (prdata),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .pstb       (pstb),
        .pready     (pready),
        .perr       (perr)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;

    // Responder behaviour for the current transfer
    int          rsp_wait = 0;
    logic        rsp_perr = 1'b0;
    logic [31:0] rsp_data = 32'h0;
    int          acc_cnt  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Responder: stalls rsp_wait ACCESS cycles (with junk perr/prdata), then completes
    initial begin
        pready = 1'b0;
        perr   = 1'b0;
        prdata = 32'h0;
        forever begin
            @(negedge clk);
            if (psel === 1'b1 && penable === 1'b1) begin
                if (acc_cnt == rsp_wait) begin
                    pready = 1'b1;
                    perr   = rsp_perr;
                    prdata = rsp_data;
                end else begin
                    pready = 1'b0;
                    perr   = 1'b1;
                    prdata = $urandom;
                end
                acc_cnt++;
            end else begin
                pready  = 1'b0;
                perr    = 1'b0;
                acc_cnt = 0;
            end
        end
    end

    // Monitor: every rsp_valid pulse must match the oldest expected response
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_rdata",   64'(rsp_rdata),   64'(e.rdata));
                    check("rsp_err",     64'(rsp_err),     64'(e.err));
                    check("rsp_timeout", 64'(rsp_timeout), 64'(e.tmo));
                end
            end
        end
    end

    task automatic do_xfer(input logic [31:0] a, input logic [31:0] wd, input logic w,
                           input logic [3:0] s, input int waits, input logic e,
                           input logic [31:0] rd, input logic exp_tmo, input int exp_lat);
        exp_t ex;
        int   k;
        bit   bad;
        bit   seen;
        @(negedge clk);
        rsp_wait  = waits;
        rsp_perr  = e;
        rsp_data  = rd;
        cmd_addr  = a;
        cmd_wdata = wd;
        cmd_write = w;
        cmd_strb  = s;
        cmd_valid = 1'b1;
        check("cmd_ready_idle", 64'(cmd_ready), 64'(1));
        ex.rdata = (w || exp_tmo) ? 32'h0 : rd;
        ex.err   = exp_tmo ? 1'b1 : e;
        ex.tmo   = exp_tmo;
        exp_q.push_back(ex);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        cmd_write = ~w;
        cmd_strb  = ~s;
        k    = 1;
        bad  = 1'b0;
        seen = 1'b0;
        while (k <= 200 && !seen) begin
            if (rsp_valid === 1'b1) begin
                seen = 1'b1;
                check("rsp_latency", 64'(k), 64'(exp_lat));
                if (psel !== 1'b0 || penable !== 1'b0 || cmd_ready !== 1'b0) bad = 1'b1;
            end else begin
                if (psel !== 1'b1 || penable !== (k > 1)) bad = 1'b1;
                if (paddr !== a || pdata !== wd || pwrite !== w || pstb !== s) bad = 1'b1;
                @(negedge clk);
                k++;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL rsp_wait_bound: got no rsp_valid expected one within 200 cycles");
        end
        check("bus_protocol", 64'(bad), 64'(0));
        @(negedge clk);
        check("cmd_ready_after", 64'(cmd_ready), 64'(1));
        check("paddr_retained",  64'(paddr),     64'(a));
        check("psel_idle",       64'(psel),      64'(0));
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        cmd_write = 1'b0;
        cmd_strb  = 4'h0;
        repeat (3) @(negedge clk);
        check("cmd_ready_in_reset", 64'(cmd_ready), 64'(0));
        check("psel_in_reset",      64'(psel),      64'(0));
        reset = 1'b0;
        @(negedge clk);
        check("reset_cmd_ready", 64'(cmd_ready), 64'(1));
        check("reset_bus", 64'({psel, penable, pwrite, pstb}), 64'(0));
        check("reset_paddr", 64'(paddr), 64'(0));
        check("reset_pdata", 64'(pdata), 64'(0));
        check("reset_rsp", 64'({rsp_valid, rsp_err, rsp_timeout, rsp_rdata}), 64'(0));

        // Zero-wait read
        do_xfer(32'h8000_0010, 32'h0, 1'b0, 4'hF, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, 3);
        // Write with three wait states; junk perr during waits must be ignored
        do_xfer(32'h1000_0000, 32'h41, 1'b1, 4'h1, 3, 1'b0, 32'hCAFE_F00D, 1'b0, 6);
        check("rsp_rdata_held", 64'(rsp_rdata), 64'(0));
        // Responder error on the second ACCESS cycle
        do_xfer(32'h0000_0100, 32'h0, 1'b0, 4'h3, 1, 1'b1, 32'h1111_2222, 1'b0, 4);
        check("rsp_err_held", 64'(rsp_err), 64'(1));
        // Timeout: pready never comes, ACCESS lasts TIMEOUT+1 cycles
        do_xfer(32'h0000_0200, 32'h5A5A_5A5A, 1'b1, 4'hC, 1000, 1'b0, 32'h0, 1'b1, 7);
        check("rsp_timeout_held", 64'(rsp_timeout), 64'(1));
        // Next command after a timeout completes normally
        do_xfer(32'h0000_0300, 32'h0, 1'b0, 4'hF, 2, 1'b0, 32'h0BAD_F00D, 1'b0, 5);
        // pready arrives exactly as the counter reaches TIMEOUT
        do_xfer(32'h0000_0400, 32'h0, 1'b0, 4'hF, 4, 1'b0, 32'h1234_5678, 1'b0, 7);
        // One cycle below the limit
        do_xfer(32'h0000_0500, 32'h77, 1'b1, 4'h8, 3, 1'b0, 32'h9999_9999, 1'b0, 6);
        do_xfer(32'h0000_0600, 32'h0, 1'b0, 4'hF, 4, 1'b0, 32'hA5A5_0F0F, 1'b0, 7);

        // Reset during ACCESS aborts the transfer with no response
        @(negedge clk);
        rsp_wait  = 1000;
        cmd_addr  = 32'hFFFF_0000;
        cmd_wdata = 32'h1234_0000;
        cmd_write = 1'b1;
        cmd_strb  = 4'hF;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_in_access", 64'({psel, penable}), 64'(3));
        reset = 1'b1;
        @(negedge clk);
        check("abort_bus", 64'({psel, penable, pwrite, pstb, cmd_ready}), 64'(0));
        check("abort_paddr", 64'(paddr), 64'(0));
        check("abort_pdata", 64'(pdata), 64'(0));
        check("abort_rsp", 64'({rsp_valid, rsp_err, rsp_timeout, rsp_rdata}), 64'(0));
        reset = 1'b0;
        @(negedge clk);
        check("abort_cmd_ready", 64'(cmd_ready), 64'(1));
        repeat (10) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/apb_initiator.md
APB_INITIATOR -- requirements
Module: apb_initiator

Interface
REQ-001 Parameters SHALL be ADDR_WIDTH, default 32, APB address width; DATA_WIDTH, default 32, APB data width; TIMEOUT, default 255, maximum ACCESS-phase wait cycles (range 1..65535).
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  request present.
REQ-006 cmd_ready  output  1  block can accept a request.
REQ-007 cmd_addr  input  ADDR_WIDTH  transfer address.
REQ-008 cmd_wdata  input  DATA_WIDTH  write data.
REQ-009 cmd_write  input  1  1 = write, 0 = read.
REQ-010 cmd_strb  input  4  byte strobes.
REQ-011 rsp_valid  output  1  one-cycle completion pulse.
REQ-012 rsp_rdata  output  DATA_WIDTH  read data.
REQ-013 rsp_err  output  1  transfer failed (perr or timeout).
REQ-014 rsp_timeout  output  1  failure was a timeout.
REQ-015 paddr  output  ADDR_WIDTH  APB address.
REQ-016 pdata  output  DATA_WIDTH  APB write data.
REQ-017 prdata  input  DATA_WIDTH  APB read data.
REQ-018 psel  output  1  APB select.
REQ-019 penable  output  1  APB enable.
REQ-020 pwrite  output  1  APB direction.
REQ-021 pstb  output  4  APB byte strobes.
REQ-022 pready  input  1  responder ready.
REQ-023 perr  input  1  responder error, valid only with pready.

Function
REQ-024 The FSM SHALL have exactly the states IDLE, SETUP, ACCESS and RESP.
REQ-025 cmd_ready SHALL be high only in IDLE and only when reset is low.
REQ-026 When cmd_valid and cmd_ready are both high at an edge, the block SHALL register addr, wdata, write and strb, and SHALL move to SETUP.
REQ-027 In SETUP, the block SHALL drive psel=1 and penable=0 for exactly one cycle, then SHALL move to ACCESS.
REQ-028 In ACCESS, the block SHALL drive psel=1 and penable=1, and SHALL hold paddr, pdata, pwrite and pstb constant from SETUP until it leaves ACCESS.
REQ-029 In ACCESS with pready=1, the block SHALL capture rsp_rdata (prdata on reads, 0 on writes), set rsp_err=perr and rsp_timeout=0, and move to RESP.
REQ-030 In ACCESS, a wait counter SHALL reset to 0 on entry and increment on every cycle with pready=0.
REQ-031 When the wait counter equals TIMEOUT with pready=0, the block SHALL move to RESP with rsp_err=1, rsp_timeout=1 and rsp_rdata=0.
REQ-032 If pready=1 in the same cycle the counter reaches TIMEOUT, pready SHALL win and the transfer SHALL complete normally.
REQ-033 In RESP, the block SHALL drive rsp_valid=1 for exactly one cycle with psel=0 and penable=0, then SHALL return to IDLE.
REQ-034 rsp_rdata, rsp_err and rsp_timeout SHALL hold their values until the next RESP.
REQ-035 Latency SHALL be: accept at edge N, SETUP in cycle N+1, ACCESS from N+2; with zero wait states rsp_valid is at N+3 and cmd_ready is high again at N+4.
REQ-036 In IDLE and RESP, psel and penable SHALL be 0; paddr, pdata and pstb SHALL retain their last values.
REQ-037 perr sampled while pready=0 SHALL be ignored.
REQ-038 cmd_* inputs SHALL be ignored outside the accept cycle.

Reset
REQ-039 While reset is high, the FSM SHALL go to IDLE at the next edge, including mid-transfer.
REQ-040 While reset is high, the wait counter, psel, penable, pwrite, rsp_valid, rsp_err and rsp_timeout SHALL clear to 0.
REQ-041 While reset is high, paddr, pdata, rsp_rdata and pstb SHALL clear to 0, and cmd_ready SHALL be 0.
REQ-042 A transfer aborted by reset SHALL produce no rsp_valid.

Verification
REQ-043 Read, addr 0x80000010, strb 0xF, pready=1 immediately, prdata 0xDEADBEEF -> psel at N+1, penable at N+2, rsp_valid at N+3 with rdata 0xDEADBEEF and err=0.
REQ-044 Write, addr 0x10000000, wdata 0x41, strb 0x1, pready low for 3 cycles -> pwrite=1 and pdata=0x41 held stable throughout; rsp_valid at N+6 with rdata 0 and err=0.
REQ-045 Read with pready=1 and perr=1 on the second ACCESS cycle -> rsp_err=1, rsp_timeout=0.
REQ-046 TIMEOUT=4, pready never asserted -> ACCESS lasts 5 cycles, then rsp_valid with err=1 and timeout=1, psel drops; a second command is then accepted normally.
REQ-047 TIMEOUT=4, pready=1 exactly in the cycle the counter reaches 4 -> normal completion, rsp_timeout=0.
REQ-048 reset asserted for one cycle during ACCESS -> all outputs are 0 the next cycle, no rsp_valid pulse, and cmd_ready=1 after reset deasserts.
